// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: the ALU opcode enums, the request bundle
// and the arbiter state encoding.
package alu_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [6:0] {
    F7_DEFAULT = 7'b0000000,
    F7_NEG     = 7'b0100000
  } alu_funct7_e;

  // 3'b001 is deliberately absent: the ALU answers it with 0.
  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_funct3_e;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    alu_funct7_e       funct7;
    alu_funct3_e       funct3;
  } alu_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response channels of the ALU arbiter, one lane per
// requester; the slave modport is the arbiter's view.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic        [NUM_REQ-1:0]             req_valid_i;
  logic        [NUM_REQ-1:0]             req_ready_o;
  logic        [NUM_REQ-1:0][DATA_W-1:0] req_op1_i;
  logic        [NUM_REQ-1:0][DATA_W-1:0] req_op2_i;
  alu_funct7_e [NUM_REQ-1:0]             req_funct7_i;
  alu_funct3_e [NUM_REQ-1:0]             req_funct3_i;
  logic        [NUM_REQ-1:0]             rsp_valid_o;
  logic        [NUM_REQ-1:0]             rsp_ready_i;
  logic        [DATA_W-1:0]              rsp_result_o;

  modport slave (
    input  req_valid_i, req_op1_i, req_op2_i, req_funct7_i, req_funct3_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o
  );

  modport master (
    output req_valid_i, req_op1_i, req_op2_i, req_funct7_i, req_funct3_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N, reported as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cidx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    cidx    = '0;
    if (en) begin
      for (int off = 0; off < N; off++) begin
        cand = int'(ptr) + off;
        if (cand >= N) cand = cand - N;
        cidx = IDX_W'(cand);
        if (!gnt_vld && req[cidx]) begin
          gnt[cidx] = 1'b1;
          gnt_idx   = cidx;
          gnt_vld   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters with
// a registered, owner-tagged result. Define ALU_ARB_STATS_EN for grant counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  alu_arbiter_if.slave      req_if,
  output logic [DATA_W-1:0] alu_operand_1_o,
  output logic [DATA_W-1:0] alu_operand_2_o,
  output alu_funct7_e       alu_funct7_o,
  output alu_funct3_e       alu_funct3_o,
  input  logic [DATA_W-1:0] alu_result_i
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][CNT_W-1:0] grant_cnt_o
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W < 1) begin : g_bad_params
    $error("alu_arbiter: NUM_REQ must be 2..8 and CNT_W at least 1");
  end

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, rr_ptr_q;
  logic [DATA_W-1:0] result_p1;
  logic              free;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;
  alu_req_t          alu_req;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // The slot frees up in the same cycle the owner consumes its response,
  // which is what allows one operation per cycle. Reset also blocks grants.
  assign free = rst_ni && ((state_q == IDLE) || req_if.rsp_ready_i[owner_q]);

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_if.req_valid_i),
    .ptr     (rr_ptr_q),
    .en      (free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // p0: granted request steers the ALU; idle drive yields a zero result
  always_comb begin
    alu_req = '{op1: '0, op2: '0, funct7: F7_DEFAULT, funct3: F3_ADD};
    if (gnt_vld) begin
      alu_req.op1    = req_if.req_op1_i[gnt_idx];
      alu_req.op2    = req_if.req_op2_i[gnt_idx];
      alu_req.funct7 = req_if.req_funct7_i[gnt_idx];
      alu_req.funct3 = req_if.req_funct3_i[gnt_idx];
    end
  end

  assign alu_operand_1_o = alu_req.op1;
  assign alu_operand_2_o = alu_req.op2;
  assign alu_funct7_o    = alu_req.funct7;
  assign alu_funct3_o    = alu_req.funct3;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_vld) begin
        owner_q  <= gnt_idx;
        rr_ptr_q <= next_ptr(gnt_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = RESP;
      RESP: begin
        if (gnt_vld)                          state_d = RESP;
        else if (req_if.rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_if.req_ready_o = gnt;
    req_if.rsp_valid_o = '0;
    if (state_q == RESP) req_if.rsp_valid_o[owner_q] = 1'b1;
  end

  // p1: registered ALU result, held until its owner consumes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      result_p1 <= '0;
    else if (gnt_vld) result_p1 <= alu_result_i;
  end

  assign req_if.rsp_result_o = result_p1;

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
      end
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a
// cycle-level transaction model of the round-robin sharing rules.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N = 2;
`ifdef ALU_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(N)) bus ();

  logic [31:0] alu_op1, alu_op2, alu_res;
  alu_funct7_e alu_f7;
  alu_funct3_e alu_f3;
`ifdef ALU_ARB_STATS_EN
  logic [N-1:0][CW-1:0] grant_cnt;
`endif

  alu_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_if          (bus.slave),
    .alu_operand_1_o (alu_op1),
    .alu_operand_2_o (alu_op2),
    .alu_funct7_o    (alu_f7),
    .alu_funct3_o    (alu_f3),
    .alu_result_i    (alu_res)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt_o     (grant_cnt)
`endif
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [6:0] f7, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      3'b000:  r = (f7 == 7'b0100000) ? a - b : a + b;
      3'b010:  r = {31'b0, $signed(a) < $signed(b)};
      3'b011:  r = {31'b0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = (f7 == 7'b0100000) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always_comb alu_res = alu_ref(alu_op1, alu_op2, alu_f7, alu_f3);

  int n_tests = 0;
  int n_fail  = 0;

  // transaction model: pointer, owner, held response, grant counts
  int          m_ptr, m_owner;
  bit          m_held;
  logic [31:0] m_res;
  int          m_cnt [N];

  function automatic void model_reset();
    m_ptr = 0; m_owner = 0; m_held = 0; m_res = 32'h0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic int exp_grant();
    int k;
    if (rst_n !== 1'b1) return -1;
    if (m_held && !bus.rsp_ready_i[m_owner]) return -1;
    for (int j = 0; j < N; j++) begin
      k = (m_ptr + j) % N;
      if (bus.req_valid_i[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input alu_funct7_e f7, input alu_funct3_e f3);
    bus.req_op1_i[i]    = a;
    bus.req_op2_i[i]    = b;
    bus.req_funct7_i[i] = f7;
    bus.req_funct3_i[i] = f3;
  endtask

  // one clock edge, with the model advanced by the same edge
  task automatic tick(output int g);
    int          eg;
    bit          rel;
    logic [31:0] er;
    eg  = exp_grant();
    rel = m_held && bus.rsp_ready_i[m_owner];
    er  = 32'h0;
    if (eg >= 0) er = alu_ref(bus.req_op1_i[eg], bus.req_op2_i[eg],
                              bus.req_funct7_i[eg], bus.req_funct3_i[eg]);
    @(posedge clk);
    if (eg >= 0) begin
      m_res = er; m_owner = eg; m_held = 1; m_ptr = (eg + 1) % N;
      if (m_cnt[eg] < CMAX) m_cnt[eg]++;
    end else if (rel) begin
      m_held = 0;
    end
    #1;
    g = eg;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid_i = '1;
    bus.rsp_ready_i = '1;
    @(posedge clk); #1;
    n_tests++; if (bus.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", bus.req_ready_o); end
    n_tests++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid_o); end
    n_tests++; if (bus.rsp_result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.rsp_result_o); end
`ifdef ALU_ARB_STATS_EN
    n_tests++; if (grant_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", grant_cnt); end
`endif
    bus.req_valid_i = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    int g;
    set_req(0, 32'd5, 32'd3, F7_NEG, F3_ADD);
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b11;
    #1;
    n_tests++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", bus.req_ready_o); end
    n_tests++; if ({alu_op1, alu_op2} !== {32'd5, 32'd3}) begin n_fail++; $display("FAIL single_alu_ops: got %h %h want 5 3", alu_op1, alu_op2); end
    tick(g);
    bus.req_valid_i = 2'b00;
    n_tests++; if (bus.rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 01", bus.rsp_valid_o); end
    n_tests++; if (bus.rsp_result_o !== 32'd2) begin n_fail++; $display("FAIL single_result: got %0d want 2", bus.rsp_result_o); end
    #1;
    n_tests++; if (bus.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL single_idle_ready: got %b want 00", bus.req_ready_o); end
    tick(g);
    n_tests++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL single_release: got %b want 00", bus.rsp_valid_o); end
  endtask

  task automatic test_fairness();
    int g;
    apply_reset();
    set_req(0, 32'hF0, 32'h0F, F7_DEFAULT, F3_OR);
    set_req(1, 32'hFF, 32'h0F, F7_DEFAULT, F3_XOR);
    bus.req_valid_i = 2'b11;
    bus.rsp_ready_i = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++; if (bus.req_ready_o !== onehot(c % 2)) begin n_fail++; $display("FAIL fair_ready[%0d]: got %b want %b", c, bus.req_ready_o, onehot(c % 2)); end
      tick(g);
      n_tests++; if (bus.rsp_valid_o !== onehot(c % 2)) begin n_fail++; $display("FAIL fair_rsp_valid[%0d]: got %b want %b", c, bus.rsp_valid_o, onehot(c % 2)); end
      n_tests++; if (bus.rsp_result_o !== ((c % 2) ? 32'hF0 : 32'hFF)) begin n_fail++; $display("FAIL fair_result[%0d]: got %h want %h", c, bus.rsp_result_o, (c % 2) ? 32'hF0 : 32'hFF); end
    end
    bus.req_valid_i = 2'b00;
  endtask

  task automatic test_backpressure();
    int g;
    set_req(0, 32'd10, 32'd20, F7_DEFAULT, F3_ADD);
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b11;
    #1;
    n_tests++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL bp_first_ready: got %b want 01", bus.req_ready_o); end
    tick(g);
    n_tests++; if (bus.rsp_result_o !== 32'd30) begin n_fail++; $display("FAIL bp_first_result: got %0d want 30", bus.rsp_result_o); end
    set_req(1, 32'hFF, 32'h3C, F7_DEFAULT, F3_AND);
    bus.req_valid_i = 2'b10;
    bus.rsp_ready_i = 2'b10;   // only the non-owner is ready
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (bus.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 00", c, bus.req_ready_o); end
      n_tests++; if ({alu_op1, alu_op2, alu_f7, alu_f3} !== {32'h0, 32'h0, F7_DEFAULT, F3_ADD}) begin n_fail++; $display("FAIL bp_idle_alu[%0d]: got %h %h %h %h want 0 0 0 0", c, alu_op1, alu_op2, alu_f7, alu_f3); end
      tick(g);
      n_tests++; if (bus.rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b want 01", c, bus.rsp_valid_o); end
      n_tests++; if (bus.rsp_result_o !== 32'd30) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %0d want 30", c, bus.rsp_result_o); end
    end
    bus.rsp_ready_i = 2'b01;
    #1;
    n_tests++; if (bus.req_ready_o !== 2'b10) begin n_fail++; $display("FAIL bp_release_ready: got %b want 10", bus.req_ready_o); end
    tick(g);
    bus.req_valid_i = 2'b00;
    bus.rsp_ready_i = 2'b00;
    n_tests++; if (bus.rsp_valid_o !== 2'b10) begin n_fail++; $display("FAIL bp_next_valid: got %b want 10", bus.rsp_valid_o); end
    n_tests++; if (bus.rsp_result_o !== 32'h3C) begin n_fail++; $display("FAIL bp_next_result: got %h want 3c", bus.rsp_result_o); end
  endtask

  task automatic test_async_reset();
    int g;
    #1;
    n_tests++; if (bus.rsp_valid_o !== 2'b10) begin n_fail++; $display("FAIL areset_pre_valid: got %b want 10", bus.rsp_valid_o); end
    set_req(0, 32'd1, 32'd1, F7_DEFAULT, F3_ADD);
    bus.req_valid_i = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.rsp_valid_o !== 2'b00) begin n_fail++; $display("FAIL areset_valid: got %b want 00", bus.rsp_valid_o); end
    n_tests++; if (bus.rsp_result_o !== 32'h0) begin n_fail++; $display("FAIL areset_result: got %h want 0", bus.rsp_result_o); end
    n_tests++; if (bus.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL areset_ready: got %b want 00", bus.req_ready_o); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready_i = 2'b11;
    #1;
    n_tests++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL areset_first_grant: got %b want 01", bus.req_ready_o); end
    tick(g);
    bus.req_valid_i = 2'b00;
    n_tests++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== 32'd2) begin n_fail++; $display("FAIL areset_first_rsp: got %b/%0d want 01/2", bus.rsp_valid_o, bus.rsp_result_o); end
  endtask

  task automatic test_unsupported();
    int g;
    set_req(0, 32'd7, 32'd9, F7_DEFAULT, alu_funct3_e'(3'b001));
    bus.req_valid_i = 2'b01;
    bus.rsp_ready_i = 2'b11;
    #1;
    n_tests++; if (bus.req_ready_o !== 2'b01) begin n_fail++; $display("FAIL unsup_ready: got %b want 01", bus.req_ready_o); end
    tick(g);
    bus.req_valid_i = 2'b00;
    n_tests++; if (bus.rsp_valid_o !== 2'b01) begin n_fail++; $display("FAIL unsup_valid: got %b want 01", bus.rsp_valid_o); end
    n_tests++; if (bus.rsp_result_o !== 32'h0) begin n_fail++; $display("FAIL unsup_result: got %h want 0", bus.rsp_result_o); end
  endtask

  task automatic test_random();
    int g, eg;
    bit pend [N];
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          set_req(i, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                  ($urandom_range(0, 1) != 0) ? F7_NEG : F7_DEFAULT,
                  alu_funct3_e'(3'($urandom_range(0, 7))));
          pend[i] = 1;
        end
        bus.req_valid_i[i] = pend[i];
        bus.rsp_ready_i[i] = ($urandom_range(0, 3) != 0);
      end
      #1;
      eg = exp_grant();
      n_tests++; if (bus.req_ready_o !== onehot(eg)) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.req_ready_o, onehot(eg)); end
      if (eg >= 0) begin
        n_tests++; if ({alu_op1, alu_op2} !== {bus.req_op1_i[eg], bus.req_op2_i[eg]}) begin n_fail++; $display("FAIL rand_alu_ops[%0d]: got %h %h want %h %h", c, alu_op1, alu_op2, bus.req_op1_i[eg], bus.req_op2_i[eg]); end
      end
      tick(g);
      if (g >= 0) pend[g] = 0;
      n_tests++; if (bus.rsp_valid_o !== (m_held ? onehot(m_owner) : 2'b00)) begin n_fail++; $display("FAIL rand_rsp_valid[%0d]: got %b want %b", c, bus.rsp_valid_o, m_held ? onehot(m_owner) : 2'b00); end
      if (m_held) begin
        n_tests++; if (bus.rsp_result_o !== m_res) begin n_fail++; $display("FAIL rand_result[%0d]: got %h want %h", c, bus.rsp_result_o, m_res); end
      end
`ifdef ALU_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
        n_tests++; if (grant_cnt[i] !== CW'(m_cnt[i])) begin n_fail++; $display("FAIL rand_cnt%0d[%0d]: got %0d want %0d", i, c, grant_cnt[i], m_cnt[i]); end
      end
`endif
    end
    bus.req_valid_i = '0;
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    int g;
    apply_reset();
    set_req(1, 32'd4, 32'd4, F7_DEFAULT, F3_ADD);
    bus.req_valid_i = 2'b10;
    bus.rsp_ready_i = 2'b11;
    for (int c = 0; c < 20; c++) begin
      #1;
      tick(g);
    end
    bus.req_valid_i = 2'b00;
    n_tests++; if (grant_cnt[1] !== 4'd15) begin n_fail++; $display("FAIL stats_cnt1: got %0d want 15", grant_cnt[1]); end
    n_tests++; if (grant_cnt[0] !== 4'd0) begin n_fail++; $display("FAIL stats_cnt0: got %0d want 0", grant_cnt[0]); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, F7_DEFAULT, F3_ADD);
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_async_reset();
    test_unsupported();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` between NUM_REQ requesters, e.g. the execute stage and an address-generation or CSR unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin, at most one operation per cycle.
- Each result is registered and returned to the requester that issued it.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- CNT_W, 16, width of each grant counter; used only when ALU_ARB_STATS_EN is defined.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  request valid, one bit per requester.
- req_ready_o  out  NUM_REQ  request accepted this cycle; at most one bit high.
- req_op1_i  in  NUM_REQ x 32  operand 1 per requester.
- req_op2_i  in  NUM_REQ x 32  operand 2 per requester.
- req_funct7_i  in  NUM_REQ x alu_funct7_e  funct7 per requester.
- req_funct3_i  in  NUM_REQ x alu_funct3_e  funct3 per requester.
- rsp_valid_o  out  NUM_REQ  response valid, one-hot or zero.
- rsp_ready_i  in  NUM_REQ  response consumed.
- rsp_result_o  out  32  registered result; shared by all requesters, qualified by rsp_valid_o.
- alu_operand_1_o  out  32  to alu operand_1_i.
- alu_operand_2_o  out  32  to alu operand_2_i.
- alu_funct7_o  out  alu_funct7_e  to alu funct7_i.
- alu_funct3_o  out  alu_funct3_e  to alu funct3_i.
- alu_result_i  in  32  from alu result_o.
- grant_cnt_o  out  NUM_REQ x CNT_W  per-requester grant counts; present only with ALU_ARB_STATS_EN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, owner=0.
  - rsp_valid_o=0, rsp_result_o=0, req_ready_o=0.
  - Counters cleared.
  - Reset mid-operation discards any held response; nothing is replayed.
- States:
  - IDLE: no response held.
  - RESP: response held for `owner`.
- Slot free condition: `free = (state==IDLE) || rsp_ready_i[owner]`.
- Grant (combinational):
  - When free, pick the first requester with req_valid_i high, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready_o[g]=1 only for that requester g; all other bits 0.
  - No grant when not free or when no requester is valid.
- ALU drive:
  - With a grant, the ALU ports carry requester g's op1/op2/funct7/funct3 in the same cycle.
  - Otherwise ALU ports are driven 0, funct7 default and funct3 ADD, so the ALU result is 0.
- Accept edge (req_valid_i[g] & req_ready_o[g]):
  - rsp_result_o <= alu_result_i.
  - owner <= g; state <= RESP.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: result visible exactly 1 cycle after accept.
- Throughput: 1 op/cycle when the owner's rsp_ready_i stays high. A release and a new accept in the same cycle go straight to RESP with the new owner.
- Release without accept: RESP and rsp_ready_i[owner]=1 with no grant -> IDLE, rsp_valid_o cleared next cycle.
- Backpressure: in RESP with rsp_ready_i[owner]=0:
  - rsp_result_o and rsp_valid_o are held stable.
  - No grant; rr_ptr is unchanged.
- Response valid: rsp_valid_o[i] = (state==RESP) && (owner==i).
- rsp_ready_i bits of non-owners are ignored.
- Requester protocol: once req_valid_i is high, the requester holds valid and payload stable until ready. The arbiter never depends on a requester withdrawing valid.
- Unsupported funct3 passes through; the ALU returns 0 and the handshake completes normally.
- Arithmetic is the ALU's (32-bit, wrap-around). The arbiter never modifies operands.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - One CNT_W-bit counter per requester, incremented on each accept for that requester.
  - Counters saturate at all-ones and do not wrap.
  - Cleared by reset; exposed on grant_cnt_o.
- Undefined: no counters and no grant_cnt_o port; arbitration behaviour is identical.

Decomposition:
- Package `types`:
  - add alu_req_t struct {op1, op2, funct7 (alu_funct7_e), funct3 (alu_funct3_e)}.
  - add arb_state_e {IDLE, RESP}.
  - These sit beside the existing ALU enums.
- Sub-module `rr_arbiter`:
  - purely combinational.
  - inputs: request vector, pointer, enable.
  - output: one-hot grant plus its index.
  - reusable for later shared resources.
- FSM, owner, result register and counters stay in alu_arbiter.

Test Plan:
- Single request: req0 op1=5, op2=3, funct7=NEG, funct3=ADD -> req_ready_o=01 the same cycle; next cycle rsp_valid_o=01 and rsp_result_o=2.
- Fairness: req0 and req1 valid every cycle, rsp_ready_i=11 -> grants alternate 0,1,0,1 over 8 cycles with one result per cycle. Results: 0xF0 OR 0x0F=0xFF for req0; 0xFF XOR 0x0F=0xF0 for req1.
- Backpressure: response held for req0 with rsp_ready_i[0]=0 for 3 cycles while req1 is valid -> rsp_result_o stable, req_ready_o=00 for 3 cycles. When rsp_ready_i[0]=1, req1 is granted that same cycle.
- Async reset mid-op: rst_ni pulled low while rsp_valid_o=10 -> rsp_valid_o=00 and rsp_result_o=0 immediately. After release with both requesters valid, the first grant goes to req0.
- Unsupported funct3 (e.g. 3'b001), op1=7, op2=9 -> handshake completes and rsp_result_o=0.
- With ALU_ARB_STATS_EN, CNT_W=4: 20 accepts for req1 -> grant_cnt_o[1]=15 and grant_cnt_o[0]=0.
